// File: rtl/miriscv_rvfi_serializer.sv
// miriscv_rvfi_serializer
//   Serializes up to NRET retire records per cycle (RVFI style) into a
//   single-entry-per-cycle stream through a DEPTH-entry circular buffer.
//   Valid lanes are compacted in ascending lane order. A cycle's group is
//   pushed whole or not at all. The head entry is presented with
//   valid/ready handshaking. The block also runs an order-continuity check
//   and a retire counter.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   clr_i                synchronous clear of overflow/order_err/retired count
//   rvfi_*_i             per-lane retire records (NRET lanes, packed buses)
//   out_valid_o/ready_i  head entry handshake
//   out_*_o              head entry fields (undefined while out_valid_o=0)
//   level_o              buffer occupancy
//   overflow_o           sticky: a retire group was dropped for lack of space
//   order_err_o          sticky: a popped order differed from the expected one
//   retired_cnt_o        number of entries popped (wraps at 2^64)
module miriscv_rvfi_serializer #(
  parameter int unsigned NRET  = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic [NRET-1:0]          rvfi_valid_i,
  input  logic [NRET*64-1:0]       rvfi_order_i,
  input  logic [NRET*32-1:0]       rvfi_insn_i,
  input  logic [NRET*32-1:0]       rvfi_pc_rdata_i,
  input  logic [NRET*32-1:0]       rvfi_rd_wdata_i,
  input  logic [NRET*5-1:0]        rvfi_rd_addr_i,
  input  logic [NRET-1:0]          rvfi_trap_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [63:0]              out_order_o,
  output logic [31:0]              out_insn_o,
  output logic [31:0]              out_pc_o,
  output logic [31:0]              out_rd_wdata_o,
  output logic [4:0]               out_rd_addr_o,
  output logic                     out_trap_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic                     order_err_o,
  output logic [63:0]              retired_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] rd_wdata;
    logic [4:0]  rd_addr;
    logic        trap;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        lane_entry [NRET];
  logic [AW-1:0] lane_off [NRET];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level, push_cnt, free_cnt, push_amt;
  logic          push_ok, pop;
  logic [63:0]   exp_order;
  entry_t        head;

  // Each valid lane lands at wptr + (number of valid lanes below it), which
  // squeezes out the gaps left by invalid lanes.
  always_comb begin
    push_cnt = '0;
    for (int unsigned i = 0; i < NRET; i++) begin
      lane_off[i]   = push_cnt[AW-1:0];
      lane_entry[i] = '{order:    rvfi_order_i[i*64 +: 64],
                        insn:     rvfi_insn_i[i*32 +: 32],
                        pc:       rvfi_pc_rdata_i[i*32 +: 32],
                        rd_wdata: rvfi_rd_wdata_i[i*32 +: 32],
                        rd_addr:  rvfi_rd_addr_i[i*5 +: 5],
                        trap:     rvfi_trap_i[i]};
      push_cnt = push_cnt + LW'(rvfi_valid_i[i]);
    end
  end

  // Free space comes from occupancy before this cycle's pop, so a pop does
  // not make room for a push on the same edge.
  assign free_cnt = DEPTH_L - level;
  assign push_ok  = (push_cnt <= free_cnt);
  assign push_amt = push_ok ? push_cnt : '0;
  assign pop      = out_valid_o && out_ready_i;

  // Storage is not reset; contents are only meaningful below level.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      for (int unsigned i = 0; i < NRET; i++) begin
        if (rvfi_valid_i[i]) begin
          mem[wptr + lane_off[i]] <= lane_entry[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr          <= '0;
      rptr          <= '0;
      level         <= '0;
      exp_order     <= '0;
      overflow_o    <= 1'b0;
      order_err_o   <= 1'b0;
      retired_cnt_o <= '0;
    end else begin
      wptr  <= wptr + push_amt[AW-1:0];
      level <= level + push_amt - LW'(pop);
      if (pop) begin
        rptr      <= rptr + AW'(1);
        exp_order <= head.order + 64'd1;
      end

      if (clr_i) begin
        overflow_o    <= 1'b0;
        order_err_o   <= 1'b0;
        retired_cnt_o <= '0;
      end else begin
        if (!push_ok) begin
          overflow_o <= 1'b1;
        end
        if (pop && (head.order != exp_order)) begin
          order_err_o <= 1'b1;
        end
        if (pop) begin
          retired_cnt_o <= retired_cnt_o + 64'd1;
        end
      end
    end
  end

  assign head           = mem[rptr];
  assign out_valid_o    = (level != '0);
  assign out_order_o    = head.order;
  assign out_insn_o     = head.insn;
  assign out_pc_o       = head.pc;
  assign out_rd_wdata_o = head.rd_wdata;
  assign out_rd_addr_o  = head.rd_addr;
  assign out_trap_o     = head.trap;
  assign level_o        = level;

endmodule

// File: tb/tb_miriscv_rvfi_serializer.sv
// Self-checking bench for miriscv_rvfi_serializer (NRET=2, DEPTH=8).
// A queue-based reference model is updated on every clock edge. A compare
// process checks every DUT output against it on each falling edge. Directed
// scenarios add hand-computed literal expectations.
module tb_miriscv_rvfi_serializer;

  localparam int unsigned NRET  = 2;
  localparam int unsigned DEPTH = 8;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   clr_i = 1'b0;
  logic [NRET-1:0]        rvfi_valid_i = '0;
  logic [NRET*64-1:0]     rvfi_order_i = '0;
  logic [NRET*32-1:0]     rvfi_insn_i = '0;
  logic [NRET*32-1:0]     rvfi_pc_rdata_i = '0;
  logic [NRET*32-1:0]     rvfi_rd_wdata_i = '0;
  logic [NRET*5-1:0]      rvfi_rd_addr_i = '0;
  logic [NRET-1:0]        rvfi_trap_i = '0;
  logic                   out_valid_o;
  logic                   out_ready_i = 1'b0;
  logic [63:0]            out_order_o;
  logic [31:0]            out_insn_o;
  logic [31:0]            out_pc_o;
  logic [31:0]            out_rd_wdata_o;
  logic [4:0]             out_rd_addr_o;
  logic                   out_trap_o;
  logic [$clog2(DEPTH):0] level_o;
  logic                   overflow_o;
  logic                   order_err_o;
  logic [63:0]            retired_cnt_o;

  miriscv_rvfi_serializer #(.NRET(NRET), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
    .rvfi_valid_i(rvfi_valid_i), .rvfi_order_i(rvfi_order_i),
    .rvfi_insn_i(rvfi_insn_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i),
    .rvfi_rd_wdata_i(rvfi_rd_wdata_i), .rvfi_rd_addr_i(rvfi_rd_addr_i),
    .rvfi_trap_i(rvfi_trap_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_order_o(out_order_o), .out_insn_o(out_insn_o), .out_pc_o(out_pc_o),
    .out_rd_wdata_o(out_rd_wdata_o), .out_rd_addr_o(out_rd_addr_o),
    .out_trap_o(out_trap_o), .level_o(level_o),
    .overflow_o(overflow_o), .order_err_o(order_err_o),
    .retired_cnt_o(retired_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] order;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        trap;
  } ent_t;

  ent_t        q[$];
  ent_t        m_e;
  logic [63:0] m_exp  = '0;
  logic [63:0] m_rcnt = '0;
  logic        m_ovf  = 1'b0;
  logic        m_oerr = 1'b0;
  int          m_free, m_n;
  bit          m_pop;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q.delete();
      m_exp = '0; m_rcnt = '0; m_ovf = 1'b0; m_oerr = 1'b0;
    end else begin
      m_free = DEPTH - q.size();
      m_n    = $countones(rvfi_valid_i);
      m_pop  = (q.size() != 0) && out_ready_i;
      if (m_pop) begin
        m_e = q.pop_front();
        if (m_e.order != m_exp) m_oerr = 1'b1;
        m_exp  = m_e.order + 64'd1;
        m_rcnt = m_rcnt + 64'd1;
      end
      if (m_n <= m_free) begin
        for (int l = 0; l < NRET; l++) begin
          if (rvfi_valid_i[l]) begin
            m_e.order = rvfi_order_i[l*64 +: 64];
            m_e.insn  = rvfi_insn_i[l*32 +: 32];
            m_e.pc    = rvfi_pc_rdata_i[l*32 +: 32];
            m_e.wdata = rvfi_rd_wdata_i[l*32 +: 32];
            m_e.rd    = rvfi_rd_addr_i[l*5 +: 5];
            m_e.trap  = rvfi_trap_i[l];
            q.push_back(m_e);
          end
        end
      end else begin
        m_ovf = 1'b1;
      end
      if (clr_i) begin
        m_ovf = 1'b0; m_oerr = 1'b0; m_rcnt = '0;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk_i) begin
    chk("valid", 64'(out_valid_o), 64'(q.size() != 0));
    chk("level", 64'(level_o), 64'(q.size()));
    if (q.size() != 0) begin
      chk("order", out_order_o, q[0].order);
      chk("insn", 64'(out_insn_o), 64'(q[0].insn));
      chk("pc", 64'(out_pc_o), 64'(q[0].pc));
      chk("wdata", 64'(out_rd_wdata_o), 64'(q[0].wdata));
      chk("rd_addr", 64'(out_rd_addr_o), 64'(q[0].rd));
      chk("trap", 64'(out_trap_o), 64'(q[0].trap));
    end
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    chk("order_err", 64'(order_err_o), 64'(m_oerr));
    chk("retired", retired_cnt_o, m_rcnt);
  end

  // ---------------- stimulus ----------------
  task automatic set_lane(input int l, input logic [63:0] o);
    rvfi_order_i[l*64 +: 64]    = o;
    rvfi_insn_i[l*32 +: 32]     = o[31:0] ^ 32'hA5A5_0000;
    rvfi_pc_rdata_i[l*32 +: 32] = {o[29:0], 2'b00};
    rvfi_rd_wdata_i[l*32 +: 32] = ~o[31:0];
    rvfi_rd_addr_i[l*5 +: 5]    = o[4:0];
    rvfi_trap_i[l]              = o[0] ^ o[1];
  endtask

  // One clock: inputs held across the rising edge, idle afterwards.
  task automatic cyc(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                     input logic rdy, input logic clr);
    rvfi_valid_i = v;
    set_lane(0, o0);
    set_lane(1, o1);
    out_ready_i = rdy;
    clr_i       = clr;
    @(negedge clk_i);
    rvfi_valid_i = '0;
    out_ready_i  = 1'b0;
    clr_i        = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_level", 64'(level_o), 64'd0);
    chk("async_rst_valid", 64'(out_valid_o), 64'd0);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  logic [63:0] nxt;
  logic [1:0]  pat [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00};

  initial begin
    @(negedge clk_i);
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    chk("rst_order_err", 64'(order_err_o), 64'd0);
    chk("rst_retired", retired_cnt_o, 64'd0);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);

    // two lanes, orders 0 and 1, consumer always ready
    cyc(2'b11, 64'd0, 64'd1, 1'b1, 1'b0);
    chk("s1_level", 64'(level_o), 64'd2);
    chk("s1_first", out_order_o, 64'd0);
    cyc(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
    chk("s1_second", out_order_o, 64'd1);
    cyc(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
    chk("s1_retired", retired_cnt_o, 64'd2);
    chk("s1_order_err", 64'(order_err_o), 64'd0);

    // order gap: lane 1 only, order 5 against expected 0
    do_reset();
    cyc(2'b10, 64'd0, 64'd5, 1'b0, 1'b0);
    chk("s2_head", out_order_o, 64'd5);
    chk("s2_no_err_yet", 64'(order_err_o), 64'd0);
    cyc(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
    chk("s2_err", 64'(order_err_o), 64'd1);
    cyc(2'b01, 64'd6, 64'd0, 1'b0, 1'b0);
    cyc(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
    chk("s2_err_sticky", 64'(order_err_o), 64'd1);
    cyc(2'b00, 64'd0, 64'd0, 1'b0, 1'b1);
    chk("s2_err_clr", 64'(order_err_o), 64'd0);
    chk("s2_retired_clr", retired_cnt_o, 64'd0);

    // fill to DEPTH, then overflow (expected order is now 7)
    for (int k = 0; k < 4; k++)
      cyc(2'b11, 64'(7 + 2*k), 64'(8 + 2*k), 1'b0, 1'b0);
    chk("s3_full", 64'(level_o), 64'd8);
    cyc(2'b11, 64'd15, 64'd16, 1'b0, 1'b0);
    chk("s3_full_hold", 64'(level_o), 64'd8);
    chk("s3_overflow", 64'(overflow_o), 64'd1);
    cyc(2'b00, 64'd0, 64'd0, 1'b1, 1'b1);
    chk("s3_level7", 64'(level_o), 64'd7);
    chk("s3_ovf_clr", 64'(overflow_o), 64'd0);
    // level 7: two-entry push with same-cycle pop must be dropped whole
    cyc(2'b11, 64'd15, 64'd16, 1'b1, 1'b0);
    chk("s3_drop_level", 64'(level_o), 64'd6);
    chk("s3_drop_ovf", 64'(overflow_o), 64'd1);
    chk("s3_head9", out_order_o, 64'd9);
    for (int k = 0; k < 6; k++) cyc(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
    chk("s3_drained", 64'(level_o), 64'd0);
    chk("s3_no_order_err", 64'(order_err_o), 64'd0);

    // 20 entries streamed, consumer ready toggling, pointers wrap
    cyc(2'b00, 64'd0, 64'd0, 1'b0, 1'b1);
    nxt = 64'd15;
    for (int k = 0; nxt < 64'd35; k++) begin
      logic [1:0]  v;
      logic [63:0] o0, o1;
      v = pat[k % 8];
      if (nxt == 64'd34 && v == 2'b11) v = 2'b01;
      o0 = 64'd0; o1 = 64'd0;
      if (v[0]) begin o0 = nxt; nxt = nxt + 64'd1; end
      if (v[1]) begin o1 = nxt; nxt = nxt + 64'd1; end
      cyc(v, o0, o1, 1'(k % 2), 1'b0);
    end
    for (int k = 0; k < 60 && q.size() != 0; k++)
      cyc(2'b00, 64'd0, 64'd0, 1'(k % 2), 1'b0);
    chk("s4_drain_bound", 64'(q.size()), 64'd0);
    chk("s4_retired", retired_cnt_o, 64'd20);
    chk("s4_order_err", 64'(order_err_o), 64'd0);
    chk("s4_overflow", 64'(overflow_o), 64'd0);

    // async reset with level 5, then clear racing a pop
    cyc(2'b11, 64'd35, 64'd36, 1'b0, 1'b0);
    cyc(2'b11, 64'd37, 64'd38, 1'b0, 1'b0);
    cyc(2'b01, 64'd39, 64'd0, 1'b0, 1'b0);
    chk("s5_level5", 64'(level_o), 64'd5);
    do_reset();
    chk("s5_post_rst_level", 64'(level_o), 64'd0);
    cyc(2'b01, 64'd0, 64'd0, 1'b0, 1'b0);
    chk("s5_level1", 64'(level_o), 64'd1);
    cyc(2'b00, 64'd0, 64'd0, 1'b1, 1'b1);
    chk("s5_clr_wins", retired_cnt_o, 64'd0);
    chk("s5_level0", 64'(level_o), 64'd0);
    chk("s5_order_ok", 64'(order_err_o), 64'd0);

    @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/miriscv_rvfi_serializer.md
MIRISCV_RVFI_SERIALIZER -- requirements
Module: miriscv_rvfi_serializer

Interface
REQ-001 SHALL have parameter NRET, default 2, number of retire lanes per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 8, buffer entries, power of two, DEPTH >= 2*NRET.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr_i  input  1  synchronous clear of sticky flags and retire counter.
REQ-006 SHALL have port rvfi_valid_i  input  NRET  per-lane retire valid.
REQ-007 SHALL have port rvfi_order_i  input  NRET*64  per-lane retire order.
REQ-008 SHALL have ports rvfi_insn_i, rvfi_pc_rdata_i, rvfi_rd_wdata_i  input  NRET*32 each  per-lane instruction, PC, rd write data.
REQ-009 SHALL have ports rvfi_rd_addr_i  input  NRET*5, and rvfi_trap_i  input  NRET.
REQ-010 SHALL have port out_valid_o  output  1  head entry available.
REQ-011 SHALL have port out_ready_i  input  1  consumer accepts head entry.
REQ-012 SHALL have ports out_order_o 64, out_insn_o 32, out_pc_o 32, out_rd_wdata_o 32, out_rd_addr_o 5, out_trap_o 1, all outputs, head entry fields.
REQ-013 SHALL have port level_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have ports overflow_o, order_err_o  output  1 each  sticky error flags.
REQ-015 SHALL have port retired_cnt_o  output  64  count of entries popped.

Function
REQ-016 SHALL push, each cycle, all valid lanes in ascending lane index, compacting invalid lanes (lanes need not be contiguous).
REQ-017 SHALL compute free space from occupancy before any same-cycle pop; push only if popcount(rvfi_valid_i) <= DEPTH - level_o.
REQ-018 SHALL, when push space is insufficient, drop the whole cycle's group (no partial push) and set overflow_o at that edge.
REQ-019 SHALL pop one entry when out_valid_o && out_ready_i; out_valid_o = (level_o != 0), head fields combinationally from storage.
REQ-020 SHALL make a pushed entry visible at outputs in the cycle after the push edge (latency 1); no bypass from inputs.
REQ-021 SHALL update level_o by +pushed -popped on same edge; simultaneous push and pop permitted.
REQ-022 SHALL wrap read/write pointers modulo DEPTH.
REQ-023 SHALL hold expected-order register (reset 0); on pop, if out_order_o != expected set order_err_o; then expected = out_order_o + 1 (resync).
REQ-024 SHALL increment retired_cnt_o by 1 per pop, wrapping at 2^64.
REQ-025 SHALL on clr_i clear overflow_o, order_err_o, retired_cnt_o; clr_i wins over same-cycle set/increment; buffer and expected order unaffected.
REQ-026 SHALL hold out fields stable while out_valid_o && !out_ready_i.

Reset
REQ-027 SHALL on rst_ni low immediately clear pointers, level_o=0, out_valid_o=0, overflow_o=0, order_err_o=0, retired_cnt_o=0, expected order=0.
REQ-028 SHALL NOT reset storage array; out field values undefined while out_valid_o=0.
REQ-029 SHALL discard in-flight entries on reset mid-operation; first post-reset pop compares against order 0.

Verification
REQ-030 NRET=2: lanes 0,1 valid orders 0,1 one cycle, out_ready_i=1 -> out orders 0 then 1 on consecutive cycles, retired_cnt_o=2, order_err_o=0.
REQ-031 valid=2'b10 order 5 after expected 0 -> output order 5, order_err_o=1; next order 6 -> no new error, flag stays 1 until clr_i.
REQ-032 DEPTH=8, out_ready_i=0, push 2/cycle for 4 cycles -> level_o=8; fifth push -> dropped, overflow_o=1, level_o=8.
REQ-033 level_o=7, push 2 with same-cycle pop -> whole group dropped, overflow_o=1, level_o=6.
REQ-034 20 entries streamed with out_ready_i toggling 1/0 -> in-order output, pointers wrap, retired_cnt_o=20, fields stable while stalled.
REQ-035 rst_ni low with level_o=5 -> level_o=0, out_valid_o=0 asynchronously; clr_i with pop in same cycle -> retired_cnt_o=0.
